// File: rtl/bennett_clock.sv
// Bennett adiabatic clock generator: PHASES staggered phase clocks,
// a master charge clock and a one-cycle instruction-boundary pulse.
//
// Ports:
//   clk      - system clock, all state moves on its rising edge
//   reset    - asynchronous active-high clear
//   clkp     - positive phase clocks, bit 0 rises first, falls last
//   Mclk     - high during the charge half of each period
//   instFlag - high in the last step of each period
//
// Build option: define BENNETT_IDLE_EN to append one all-low idle
// step after the discharge half (period 2*PHASES+1); instFlag then
// moves to that idle step.

module bennett_clock #(
  parameter int PHASES = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PHASES-1:0] clkp,
  output logic              Mclk,
  output logic              instFlag
);

  // Steps in one period.
`ifdef BENNETT_IDLE_EN
  localparam int L = 2*PHASES + 1;
`else
  localparam int L = 2*PHASES;
`endif

  localparam int SW = $clog2(L);

  typedef logic [SW-1:0] step_t;

  localparam step_t S_LAST = step_t'(L - 1);
  localparam step_t S_DIS  = step_t'(PHASES);
  localparam step_t S_END  = step_t'(2*PHASES - 1);

  generate
    if (PHASES < 2 || PHASES > 32) begin : g_bad
      $error("bennett_clock: PHASES out of range 2..32");
    end
  endgenerate

  // Low n bits set.
  function automatic logic [PHASES-1:0] ramp(input int n);
    logic [PHASES-1:0] m;
    m = '0;
    for (int i = 0; i < PHASES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  step_t             s_q;
  step_t             s_d;
  logic [PHASES-1:0] clkp_q;
  logic [PHASES-1:0] clkp_d;
  logic              mclk_q;
  logic              mclk_d;
  logic              inst_q;
  logic              inst_d;
  int                n_hi;

  // Reset parks the counter on the last step so the first edge
  // after release lands on step 0 without a special start state.
  always_comb begin
    s_d    = '0;
    n_hi   = 0;
    clkp_d = '0;
    mclk_d = 1'b0;
    inst_d = 1'b0;

    if (s_q != S_LAST) begin
      s_d = s_q + 1'b1;
    end

    // Charge: s+1 phases high. Discharge: 2P-1-s phases high.
    // Idle step (if built in): nothing high.
    if (s_d < S_DIS) begin
      n_hi = int'(s_d) + 1;
    end else if (s_d <= S_END) begin
      n_hi = 2*PHASES - 1 - int'(s_d);
    end else begin
      n_hi = 0;
    end

    clkp_d = ramp(n_hi);
    mclk_d = (s_d < S_DIS);
    inst_d = (s_d == S_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q    <= S_LAST;
      clkp_q <= '0;
      mclk_q <= 1'b0;
      inst_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      clkp_q <= clkp_d;
      mclk_q <= mclk_d;
      inst_q <= inst_d;
    end
  end

  assign clkp     = clkp_q;
  assign Mclk     = mclk_q;
  assign instFlag = inst_q;

endmodule

// File: tb/tb_bennett_clock.sv
// Directed bench for bennett_clock (PHASES=10) with an expected-value
// queue filled as each step is driven and drained after each edge.

module tb_bennett_clock;

  localparam int P = 10;
`ifdef BENNETT_IDLE_EN
  localparam int L = 2*P + 1;
`else
  localparam int L = 2*P;
`endif

  logic         clk;
  logic         reset;
  logic [P-1:0] clkp;
  logic         Mclk;
  logic         instFlag;

  int checks;
  int failures;

  typedef struct {
    string        tag;
    logic [P-1:0] c;
    logic         m;
    logic         f;
  } exp_t;

  exp_t sb[$];

  bennett_clock #(.PHASES(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .clkp     (clkp),
    .Mclk     (Mclk),
    .instFlag (instFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: phase i is high from step i through step 2P-2-i.
  task automatic model(input int s,
                       output logic [P-1:0] c,
                       output logic m,
                       output logic f);
    c = '0;
    for (int i = 0; i < P; i++) begin
      if (s >= i && s <= 2*P - 2 - i) c[i] = 1'b1;
    end
    m = (s < P);
    f = (s == L - 1);
  endtask

  task automatic push(input string tag, input int s);
    exp_t e;
    e.tag = tag;
    model(s, e.c, e.m, e.f);
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_clkp"}, 64'(clkp), 64'(e.c));
      chk({e.tag, "_mclk"}, 64'(Mclk), 64'(e.m));
      chk({e.tag, "_inst"}, 64'(instFlag), 64'(e.f));
    end
  endtask

  logic [P-1:0] prev;
  int           nchg;
  int           hi4;
  int           r2;
  int           r4;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    prev     = '0;
    hi4      = 0;
    r2       = -1;
    r4       = -1;

    // Held in reset across a clock edge.
    #1;
    chk("rst0_clkp", 64'(clkp), 64'h0);
    chk("rst0_mclk", 64'(Mclk), 64'h0);
    chk("rst0_inst", 64'(instFlag), 64'h0);
    #8;
    chk("rst1_clkp", 64'(clkp), 64'h0);
    chk("rst1_inst", 64'(instFlag), 64'h0);

    @(negedge clk);
    reset = 1'b0;

    // Two full periods plus one step into the third.
    for (int k = 1; k <= 2*L + 1; k++) begin
      push($sformatf("e%0d", k), (k - 1) % L);
      @(posedge clk);
      #1;
      pop_chk();

      nchg = $countones(prev ^ clkp);
      chk($sformatf("onechg_e%0d", k), 64'(nchg <= 1), 64'd1);

      if (k > L && k <= 2*L) begin
        if (clkp[4]) hi4++;
        if (clkp[2] && !prev[2]) r2 = k;
        if (clkp[4] && !prev[4]) r4 = k;
      end
      prev = clkp;

`ifdef BENNETT_IDLE_EN
      if (k == 20) begin
        chk("idle_e20_clkp", 64'(clkp), 64'h0);
        chk("idle_e20_inst", 64'(instFlag), 64'h0);
      end
      if (k == 21) begin
        chk("idle_e21_clkp", 64'(clkp), 64'h0);
        chk("idle_e21_inst", 64'(instFlag), 64'h1);
      end
      if (k == 22) chk("idle_e22_clkp", 64'(clkp), 64'h001);
`else
      if (k == 1)  chk("d_e1",  64'(clkp), 64'h001);
      if (k == 5)  chk("d_e5",  64'(clkp), 64'h01F);
      if (k == 10) chk("d_e10", 64'(clkp), 64'h3FF);
      if (k == 11) chk("d_e11", 64'(clkp), 64'h1FF);
      if (k == 11) chk("d_e11m", 64'(Mclk), 64'h0);
      if (k == 19) chk("d_e19", 64'(clkp), 64'h001);
      if (k == 20) chk("d_e20", 64'(clkp), 64'h000);
      if (k == 20) chk("d_e20f", 64'(instFlag), 64'h1);
      if (k == 21) chk("d_e21", 64'(clkp), 64'h001);
      if (k == 21) chk("d_e21f", 64'(instFlag), 64'h0);
`endif
    end

    // Consumer view of phase 4 over the second period.
    chk("p4_high_cycles", 64'(hi4), 64'd11);
    chk("p2_to_p4_lead", 64'(r4 - r2), 64'd2);

    // Advance to step 13 of the next period.
    for (int k = 1; k <= 13; k++) begin
      push($sformatf("m%0d", k), k);
      @(posedge clk);
      #1;
      pop_chk();
    end

    // Asynchronous abort between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("async_clkp", 64'(clkp), 64'h0);
    chk("async_mclk", 64'(Mclk), 64'h0);
    chk("async_inst", 64'(instFlag), 64'h0);
    @(posedge clk);
    #1;
    chk("hold_clkp", 64'(clkp), 64'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push($sformatf("r%0d", k), k);
      @(posedge clk);
      #1;
      pop_chk();
    end
    chk("restart_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bennett_clock.md
BENNETT_CLOCK -- requirements
Module: bennett_clock

Interface
REQ-001 SHALL have parameter PHASES, default 10, meaning the number of Bennett clock phases; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port clkp, output, PHASES bits: positive Bennett phase clocks, with bit 0 the first to rise.
- Complements are formed externally by the user (clkn = ~clkp).
REQ-005 SHALL have port Mclk, output, 1 bit: master clock, high during the charge half of each instruction period.
REQ-006 SHALL have port instFlag, output, 1 bit: one-cycle instruction-boundary pulse.
REQ-007 SHALL register all outputs, with no combinational path from clk or reset to any output other than the asynchronous clear.

Function
REQ-008 SHALL hold an internal step counter s.
- Range 0..L-1, where L = 2*PHASES (L = 2*PHASES+1 with BENNETT_IDLE_EN defined).
- Increments by 1 per clk rising edge; wraps from L-1 to 0.
REQ-009 SHALL define the first rising edge after reset deassertion as step s=0.
REQ-010 Charge half, for s in 0..PHASES-1: clkp SHALL have bits [s:0] = 1 and all other bits = 0.
- Exactly one new phase rises per cycle, in ascending order.
REQ-011 Discharge half, for s = PHASES+j with j in 0..PHASES-1: clkp SHALL have bits [PHASES-2-j:0] = 1 and all other bits = 0.
- Phases fall in descending order, one per cycle.
- All phases are 0 at j = PHASES-1.
REQ-012 Phase i SHALL be high for exactly 2*PHASES-1-2*i consecutive cycles per period.
- Outputs SHALL never show two phases changing in the same cycle.
REQ-013 Mclk SHALL be 1 when s is in 0..PHASES-1 and 0 otherwise.
REQ-014 instFlag SHALL be 1 only in the final step of the period, s = L-1, and 0 in all other steps.
REQ-015 Wrap-around: the step after s = L-1 SHALL be s=0 (clkp = 1 in bit 0 only), with no extra gap cycle other than that given by REQ-008.
REQ-016 The PHASES=2 boundary SHALL give the sequence 01, 11, 01, 00 (without macro).

Reset
REQ-017 While reset is 1, the module SHALL asynchronously force clkp=0, Mclk=0, instFlag=0 and s to its pre-start state.
- This takes effect immediately, independent of clk.
REQ-018 Reset asserted mid-period SHALL abort the sequence; no phase SHALL complete its ramp.
REQ-019 After reset release, the sequence SHALL restart at step 0 on the next clk rising edge.

Configuration
REQ-020 Macro BENNETT_IDLE_EN, when defined, SHALL append one idle step s = 2*PHASES after the discharge half.
- Period is 2*PHASES+1.
- clkp = 0 and Mclk = 0 in the idle step.
- instFlag is asserted in the idle step only, not at s = 2*PHASES-1.
REQ-021 Without BENNETT_IDLE_EN, the period SHALL be exactly 2*PHASES cycles with instFlag at s = 2*PHASES-1.

Verification
REQ-022 Reset check, PHASES=10, clk period 10 ns: hold reset 10 ns -> clkp=10'h000, Mclk=0, instFlag=0 throughout.
REQ-023 Charge ramp, release reset: edge 1 -> clkp=10'h001, Mclk=1; edge 5 -> clkp=10'h01F, so clkp[4] rises; edge 10 -> clkp=10'h3FF.
REQ-024 Discharge ramp: edge 11 -> clkp=10'h1FF, Mclk=0; edge 19 -> 10'h001; edge 20 -> 10'h000 with instFlag=1; edge 21 -> 10'h001 with instFlag=0.
REQ-025 Mid-period reset: assert reset asynchronously at step 13, between clk edges -> clkp=0 immediately; first edge after release -> clkp=10'h001.
REQ-026 Downstream use: drive a consumer from clkp[4] and ~clkp[4], and change its input on each rising edge of clkp[2] -> input stable for 2 cycles before clkp[4] rises; clkp[4] is high for 11 cycles per 20-cycle period.
REQ-027 With BENNETT_IDLE_EN defined: edge 20 -> clkp=0, instFlag=0; edge 21 -> clkp=0, instFlag=1; edge 22 -> clkp=10'h001.
